// File: rtl/rf_mp.sv
// Two-read/two-write register file with a debug read port and a post-reset zero-fill.
// Latency: reads are combinational (with write-data bypass on rd0/rd1); writes land on the rising edge.
// Backpressure: writes are ignored while ready is low (clear sequence runs for 2^AW cycles after reset).
module rf_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra0,
    output logic [DW-1:0] rd0,
    input  logic [AW-1:0] ra1,
    output logic [DW-1:0] rd1,
    input  logic [AW-1:0] ra_test,
    output logic [DW-1:0] rd_test,
    input  logic [AW-1:0] wa0,
    input  logic          we0,
    input  logic [DW-1:0] wd0,
    input  logic [AW-1:0] wa1,
    input  logic          we1,
    input  logic [DW-1:0] wd1,
    output logic          ready,
    output logic          wr_conflict
);

    localparam int DEPTH = 1 << AW;
    localparam bit ZR    = (ZERO_REG != 0);

    // The counter carries one spare bit so the terminal index is reached
    // without the counter ever wrapping back to zero mid-clear.
    localparam logic [AW:0] CLR_LAST = {1'b0, {AW{1'b1}}};

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   clr_cnt_q, clr_cnt_d;
    logic          wr_conflict_q, wr_conflict_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic          run;
    logic          clr_en;
    logic          disc0, disc1;
    logic          wr_en0, wr_en1;

    // Write qualification: no writes outside RUN, none in a reset cycle,
    // and address 0 is read-only when the zero register is enabled.
    always_comb begin
        run    = (state_q == RUN);
        clr_en = (state_q == CLEAR) && !rst;
        disc0  = ZR && (wa0 == '0);
        disc1  = ZR && (wa1 == '0);
        wr_en0 = run && !rst && we0 && !disc0;
        wr_en1 = run && !rst && we1 && !disc1;
    end

    // Next-state logic: walk the clear counter across every entry, then settle in RUN.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        wr_conflict_d = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                wr_conflict_d = wr_en0 && wr_en1 && (wa0 == wa1);
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // State register; reset restarts the clear from entry 0 regardless of state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CLEAR;
            clr_cnt_q     <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Storage update: zero-fill during CLEAR, else port 0 then port 1 so port 1 wins a collision.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[clr_cnt_q[AW-1:0]] <= '0;
        end else begin
            if (wr_en0) begin
                mem_q[wa0] <= wd0;
            end
            if (wr_en1) begin
                mem_q[wa1] <= wd1;
            end
        end
    end

    // Read ports: contents are hidden during CLEAR; rd0/rd1 forward same-cycle
    // write data (port 1 first), while rd_test always shows the stored value.
    always_comb begin
        rd0     = '0;
        rd1     = '0;
        rd_test = '0;
        if (run) begin
            if (!(ZR && (ra0 == '0))) begin
                if (wr_en1 && (wa1 == ra0)) begin
                    rd0 = wd1;
                end else if (wr_en0 && (wa0 == ra0)) begin
                    rd0 = wd0;
                end else begin
                    rd0 = mem_q[ra0];
                end
            end
            if (!(ZR && (ra1 == '0))) begin
                if (wr_en1 && (wa1 == ra1)) begin
                    rd1 = wd1;
                end else if (wr_en0 && (wa0 == ra1)) begin
                    rd1 = wd0;
                end else begin
                    rd1 = mem_q[ra1];
                end
            end
            if (!(ZR && (ra_test == '0))) begin
                rd_test = mem_q[ra_test];
            end
        end
    end

    assign ready       = (state_q == RUN);
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_rf_mp.sv
// Randomised and directed bench for rf_mp against a queue-free array model.
// Latency: outputs compared mid-cycle (negedge), model advanced on each rising edge.
// Backpressure: model tracks clear cycles remaining; writes dropped while nonzero.
module tb_rf_mp;

    logic        clk;
    logic        rst;
    logic [4:0]  ra0, ra1, ra_test, wa0, wa1;
    logic [31:0] rd0, rd1, rd_test, wd0, wd1;
    logic        we0, we1;
    logic        ready, wr_conflict;

    rf_mp #(.DW(32), .AW(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .ra0(ra0), .rd0(rd0),
        .ra1(ra1), .rd1(rd1),
        .ra_test(ra_test), .rd_test(rd_test),
        .wa0(wa0), .we0(we0), .wd0(wd0),
        .wa1(wa1), .we1(we1), .wd1(wd1),
        .ready(ready), .wr_conflict(wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: register contents, cycles of clearing still owed, expected conflict flag.
    logic [31:0] mem_m [32];
    int          clr_left = 0;
    bit          m_conf   = 0;
    bit          m_valid  = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit bypass);
        logic [31:0] v;
        if (clr_left > 0 || a == 5'd0) return 32'h0;
        v = mem_m[a];
        if (bypass && !rst) begin
            if (we1 && wa1 == a) v = wd1;
            else if (we0 && wa0 == a) v = wd0;
        end
        return v;
    endfunction

    // One clock: compare every output against the model, then advance the model on the edge.
    task automatic cyc();
        @(negedge clk);
        if (m_valid) begin
            chk_eq("rd0",         rd0,         m_read(ra0, 1));
            chk_eq("rd1",         rd1,         m_read(ra1, 1));
            chk_eq("rd_test",     rd_test,     m_read(ra_test, 0));
            chk_eq("ready",       {31'b0, ready},       {31'b0, clr_left == 0});
            chk_eq("wr_conflict", {31'b0, wr_conflict}, {31'b0, m_conf});
        end
        @(posedge clk);
        if (rst) begin
            clr_left = 32;
            m_conf   = 0;
            m_valid  = 1;
        end else if (m_valid && clr_left > 0) begin
            mem_m[32 - clr_left] = 32'h0;
            clr_left--;
            m_conf = 0;
        end else if (m_valid) begin
            m_conf = we0 && we1 && (wa0 == wa1) && (wa0 != 5'd0);
            if (we0 && wa0 != 5'd0) mem_m[wa0] = wd0;
            if (we1 && wa1 != 5'd0) mem_m[wa1] = wd1;
        end
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; rst = 0;
    endtask

    task automatic wait_ready(input string tag, input int want);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        chk_eq(tag, n, want);
    endtask

    initial begin
        rst = 1; we0 = 0; we1 = 0;
        ra0 = 0; ra1 = 0; ra_test = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        #1;

        // Reset and clear-length check.
        cyc();
        chk_eq("rst_ready", {31'b0, ready}, 32'h0);
        chk_eq("rst_conf",  {31'b0, wr_conflict}, 32'h0);
        rst = 0;
        wait_ready("clr_cycles", 32);

        // Every address reads zero after the clear.
        for (int a = 0; a < 32; a++) begin
            ra0 = a[4:0]; ra1 = 5'(31 - a); ra_test = a[4:0];
            #1;
            chk_eq("sweep_rd0", rd0, 32'h0);
            chk_eq("sweep_rd1", rd1, 32'h0);
            chk_eq("sweep_rdt", rd_test, 32'h0);
        end

        // Bypass on rd0, no bypass on rd_test.
        we0 = 1; wa0 = 5'd3; wd0 = 32'hDEADBEEF; ra0 = 5'd3; ra_test = 5'd3;
        #1;
        chk_eq("byp_rd0",  rd0, 32'hDEADBEEF);
        chk_eq("byp_rdt0", rd_test, 32'h0);
        cyc();
        idle();
        #1;
        chk_eq("byp_rdt1", rd_test, 32'hDEADBEEF);

        // Same-address dual write: port 1 wins, conflict for exactly one cycle.
        we0 = 1; we1 = 1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'h11; wd1 = 32'h22; ra1 = 5'd7; ra_test = 5'd7;
        #1;
        chk_eq("conf_byp_rd1", rd1, 32'h22);
        cyc();
        idle();
        #1;
        chk_eq("conf_flag", {31'b0, wr_conflict}, 32'h1);
        chk_eq("conf_store", rd_test, 32'h22);
        cyc();
        chk_eq("conf_flag_drop", {31'b0, wr_conflict}, 32'h0);

        // Zero register: writes discarded, no conflict on dual write to 0.
        we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra0 = 5'd0;
        #1;
        chk_eq("zr_same", rd0, 32'h0);
        we1 = 1; wa1 = 5'd0; wd1 = 32'h12345678;
        cyc();
        idle();
        #1;
        chk_eq("zr_after", rd0, 32'h0);
        chk_eq("zr_conf", {31'b0, wr_conflict}, 32'h0);

        // Reset mid-operation, then a second reset part-way through the clear.
        we0 = 1; wa0 = 5'd9; wd0 = 32'h55;
        cyc();
        idle();
        ra_test = 5'd9;
        #1;
        chk_eq("r9_written", rd_test, 32'h55);
        rst = 1;
        we0 = 1; wa0 = 5'd9; wd0 = 32'h99;
        cyc();
        idle();
        chk_eq("rst_run_ready", {31'b0, ready}, 32'h0);
        repeat (10) cyc();
        rst = 1;
        // Writes presented during CLEAR must be ignored.
        cyc();
        rst = 0;
        we0 = 1; wa0 = 5'd4; wd0 = 32'hAB;
        wait_ready("reclr_cycles", 32);
        idle();
        ra0 = 5'd9; ra_test = 5'd4;
        #1;
        chk_eq("r9_cleared", rd0, 32'h0);
        chk_eq("r4_blocked", rd_test, 32'h0);

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            we0 = $urandom_range(0, 1);
            we1 = $urandom_range(0, 1);
            wa0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wa1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wd0 = $urandom;
            wd1 = $urandom;
            ra0 = ($urandom_range(0, 1) != 0) ? wa0 : 5'($urandom);
            ra1 = ($urandom_range(0, 1) != 0) ? wa1 : 5'($urandom);
            ra_test = 5'($urandom);
            cyc();
        end
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
